mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 8, max consecutive grant cycles per owner when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: req  input  4  request from requester i; level-held while the requester wants the shared mux.
REQ-006 Port: in  input  4  mux data inputs; in[i] is requester i's data bit.
REQ-007 Port: gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-008 Port: sel  output  2  registered mux select; equals the index of the set gnt bit while busy.
REQ-009 Port: busy  output  1  registered; high when any gnt bit is set.
REQ-010 Port: out  output  1  combinational: in[sel] when busy, else 0.

Function
REQ-011 FSM shall have two states: IDLE (gnt=0) and OWNED (exactly one gnt bit set).
REQ-012 Round-robin pointer ptr (2 bits) shall mark the highest-priority index; priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 IDLE: if req != 0 at edge N, the winner by REQ-012 shall be granted with gnt/sel/busy valid after edge N (1-cycle latency); if req == 0, stay IDLE.
REQ-014 OWNED: while req[sel] stays high (and REQ-022 does not fire), gnt/sel shall be held unchanged.
REQ-015 Release: owner drops req[sel] at edge N: ptr shall become sel+1 mod 4; if other requests are pending, the next winner shall be granted at edge N with no idle cycle; otherwise go IDLE with gnt=0 at edge N.
REQ-016 Winner selection on handover shall use the updated ptr (sel+1), so the releasing owner has lowest priority.
REQ-017 A request arriving and dropping between edges without being sampled shall be ignored; no request latching.
REQ-018 gnt shall never have more than one bit set; sel shall never change while busy except on handover or preemption.
REQ-019 ptr wraps 3 -> 0.

Reset
REQ-020 rst high at an edge shall force gnt=0, sel=0, busy=0, ptr=0, hold counter=0, state IDLE, irrespective of req; out therefore reads 0.
REQ-021 Reset asserted mid-ownership shall drop the grant at that edge; the first arbitration after reset release shall start from ptr=0.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter shall count owner cycles from 1 at grant; when it reaches HOLD_MAX and any other req bit is high, the owner shall be preempted at that edge exactly as in REQ-015 (ptr=sel+1, next winner granted); if no other request is pending the owner shall keep the grant and the counter shall saturate at HOLD_MAX; the counter shall restart on every new grant.
REQ-023 Macro ARB_TIMEOUT_EN undefined: no hold counter shall be synthesized, ownership shall be unlimited, and HOLD_MAX shall be ignored.

Verification
REQ-024 Reset then req=4'b0000 for 5 cycles -> gnt=0, sel=0, busy=0, out=0 throughout.
REQ-025 From reset, req=4'b1010 held -> after one edge gnt=4'b0010, sel=1; out tracks in[1]; drop req[1] -> at the same edge gnt=4'b1000, sel=3, no idle cycle.
REQ-026 All req=4'b1111, each owner drops after 2 cycles and reasserts -> grant order 0,1,2,3,0; no index granted twice before all others.
REQ-027 Owner 2 granted, rst asserted for one cycle with req=4'b1111 -> gnt=0 at that edge; first grant after release goes to index 0.
REQ-028 ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0011 held -> gnt=0001 for 4 cycles then 0010 for 4 cycles, repeating; with req=4'b0001 only, gnt stays 0001 indefinitely.
REQ-029 ARB_TIMEOUT_EN undefined, req=4'b0011 held 50 cycles -> gnt stays 4'b0001 for all 50 cycles.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter driving a shared 1-bit mux.
// Define ARB_TIMEOUT_EN to bound each ownership to HOLD_MAX cycles.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       out
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    logic [0:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic       r_busy;
    logic [1:0] r_ptr;

    logic       w_drop;
    logic       w_preempt;
    logic       w_handoff;
    logic [1:0] w_base;
    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_win;
    logic       w_any;

    assign w_drop = r_busy && !req[r_sel];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold;

    // Preempt only when someone else is waiting; otherwise keep the grant.
    assign w_preempt = r_busy && req[r_sel]
                    && (r_hold == 8'(HOLD_MAX))
                    && (|(req & ~r_gnt));
`else
    assign w_preempt = 1'b0;
`endif

    assign w_handoff = w_drop | w_preempt;

    // On handoff the releasing owner drops to lowest priority.
    assign w_base = w_handoff ? (r_sel + 2'd1) : r_ptr;
    assign w_dbl  = {req, req} >> w_base;
    assign w_rot  = w_dbl[3:0];
    assign w_any  = |req;

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    assign w_win = w_base + w_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 4'd0;
            r_sel   <= 2'd0;
            r_busy  <= 1'b0;
            r_ptr   <= 2'd0;
`ifdef ARB_TIMEOUT_EN
            r_hold  <= 8'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= OWNED;
                        r_gnt   <= 4'd1 << w_win;
                        r_sel   <= w_win;
                        r_busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        r_hold  <= 8'd1;
`endif
                    end
                end
                OWNED: begin
                    if (w_handoff) begin
                        r_ptr <= r_sel + 2'd1;
                        if (w_any) begin
                            r_gnt  <= 4'd1 << w_win;
                            r_sel  <= w_win;
`ifdef ARB_TIMEOUT_EN
                            r_hold <= 8'd1;
`endif
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= 4'd0;
                            r_sel   <= 2'd0;
                            r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                            r_hold  <= 8'd0;
`endif
                        end
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        if (r_hold != 8'(HOLD_MAX))
                            r_hold <= r_hold + 8'd1;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 4'd0;
                    r_sel   <= 2'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;
    assign out  = r_busy ? in[r_sel] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus
// hand-written sequences for glitch, hold and timeout behaviour.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       dout;

    int n_chk;
    int n_err;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       out;
        logic       chk_sel;
    } vec_t;

    vec_t tv[$];

    mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .in   (din),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .out  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q,
                        input logic [3:0] d);
        @(negedge clk);
        rst = r;
        req = q;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] q,
                       input logic [3:0] d, input logic [3:0] g,
                       input logic [1:0] s, input logic b,
                       input logic o, input logic cs);
        vec_t v;
        v.rst = r; v.req = q; v.din = d; v.gnt = g;
        v.sel = s; v.busy = b; v.out = o; v.chk_sel = cs;
        tv.push_back(v);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        req = 4'h0;
        din = 4'h0;

        // reset, then idle with data present
        add(1, 4'hF, 4'h0, 4'h0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            add(0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 1);
        // 1010 from ptr 0 -> 1, then drop -> 3 with no idle
        add(0, 4'hA, 4'h2, 4'h2, 1, 1, 1, 1);
        add(0, 4'hA, 4'h0, 4'h2, 1, 1, 0, 1);
        add(0, 4'h8, 4'h8, 4'h8, 3, 1, 1, 1);
        add(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        // all requesting, each owner leaves after 2 cycles
        add(0, 4'hF, 4'h5, 4'h1, 0, 1, 1, 1);
        add(0, 4'hF, 4'h5, 4'h1, 0, 1, 1, 1);
        add(0, 4'hE, 4'h5, 4'h2, 1, 1, 0, 1);
        add(0, 4'hF, 4'h5, 4'h2, 1, 1, 0, 1);
        add(0, 4'hD, 4'h5, 4'h4, 2, 1, 1, 1);
        add(0, 4'hF, 4'h5, 4'h4, 2, 1, 1, 1);
        add(0, 4'hB, 4'h5, 4'h8, 3, 1, 0, 1);
        add(0, 4'hF, 4'h5, 4'h8, 3, 1, 0, 1);
        add(0, 4'h7, 4'h5, 4'h1, 0, 1, 1, 1);
        add(0, 4'hF, 4'h5, 4'h1, 0, 1, 1, 1);
        // owner 2, then reset mid-ownership
        add(0, 4'hE, 4'h5, 4'h2, 1, 1, 0, 1);
        add(0, 4'hD, 4'h5, 4'h4, 2, 1, 1, 1);
        add(1, 4'hF, 4'h5, 4'h0, 0, 0, 0, 1);
        add(0, 4'hF, 4'h5, 4'h1, 0, 1, 1, 1);
        add(0, 4'h0, 4'h5, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 4'h5, 4'h0, 0, 0, 0, 1);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst, tv[i].req, tv[i].din);
            chk($sformatf("v%0d.gnt", i), gnt, tv[i].gnt);
            chk($sformatf("v%0d.busy", i), {3'd0, busy}, {3'd0, tv[i].busy});
            chk($sformatf("v%0d.out", i), {3'd0, dout}, {3'd0, tv[i].out});
            if (tv[i].chk_sel)
                chk($sformatf("v%0d.sel", i), {2'd0, sel}, {2'd0, tv[i].sel});
        end

        // a request pulse between edges must be ignored
        step(0, 4'h0, 4'h0);
        #1 req = 4'h4;
        #2 req = 4'h0;
        @(posedge clk);
        #1;
        chk("glitch.gnt", gnt, 4'h0);
        chk("glitch.busy", {3'd0, busy}, 4'h0);

`ifdef ARB_TIMEOUT_EN
        step(1, 4'h0, 4'h0);
        for (int k = 0; k < 16; k++) begin
            step(0, 4'h3, 4'h0);
            chk($sformatf("to%0d.gnt", k), gnt,
                (((k / 4) % 2) == 0) ? 4'h1 : 4'h2);
        end
        step(1, 4'h0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            step(0, 4'h1, 4'h0);
            chk($sformatf("solo%0d.gnt", k), gnt, 4'h1);
        end
`else
        step(1, 4'h0, 4'h0);
        for (int k = 0; k < 50; k++) begin
            step(0, 4'h3, 4'h0);
            chk($sformatf("hold%0d.gnt", k), gnt, 4'h1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
